// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one single-port RAM between a CPU (A) and a DMA/video port (B).
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin contention; default build gives port A fixed priority.
module ram_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        A_REQ,
   input  logic        A_WE,
   input  logic [13:0] A_ADDR,
   input  logic [7:0]  A_DI,
   output logic [7:0]  A_DO,
   output logic        A_ACK,
   input  logic        B_REQ,
   input  logic        B_WE,
   input  logic [13:0] B_ADDR,
   input  logic [7:0]  B_DI,
   output logic [7:0]  B_DO,
   output logic        B_ACK,
   output logic [13:0] RAM_ADDR,
   output logic        RAM_WE,
   output logic        RAM_CS,
   output logic [7:0]  RAM_DI,
   input  logic [7:0]  RAM_DO
);

   typedef enum logic [1:0] {IDLE, SVC_A, SVC_B} state_t;

   state_t      state_reg, state_next;
   logic        a_elig, b_elig;
   logic        grant_a, grant_b;
   logic [7:0]  a_do_reg, b_do_reg;
   logic        a_ack_reg, b_ack_reg;
   logic [13:0] ram_addr_reg;
   logic        ram_we_reg, ram_cs_reg;
   logic [7:0]  ram_di_reg;
`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic        last_b_reg;   // 1 when port B won the most recent grant
`endif

   // A port is never re-taken in the cycle its own ACK is visible.
   assign a_elig = A_REQ & ~a_ack_reg;
   assign b_elig = B_REQ & ~b_ack_reg;

   always_comb begin
      state_next = state_reg;
      grant_a    = 1'b0;
      grant_b    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (a_elig && b_elig) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
               grant_a = last_b_reg;
               grant_b = ~last_b_reg;
`else
               grant_a = 1'b1;
`endif
            end else if (a_elig) begin
               grant_a = 1'b1;
            end else if (b_elig) begin
               grant_b = 1'b1;
            end
            if (grant_a)
               state_next = SVC_A;
            else if (grant_b)
               state_next = SVC_B;
         end
         SVC_A:   state_next = IDLE;
         SVC_B:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_do_reg     <= 8'h00;
         b_do_reg     <= 8'h00;
         a_ack_reg    <= 1'b0;
         b_ack_reg    <= 1'b0;
         ram_addr_reg <= 14'h0000;
         ram_we_reg   <= 1'b0;
         ram_cs_reg   <= 1'b0;
         ram_di_reg   <= 8'h00;
      end else begin
         a_ack_reg <= 1'b0;
         b_ack_reg <= 1'b0;
         if (grant_a) begin
            ram_addr_reg <= A_ADDR;
            ram_we_reg   <= A_WE;
            ram_di_reg   <= A_DI;
            ram_cs_reg   <= 1'b1;
         end else if (grant_b) begin
            ram_addr_reg <= B_ADDR;
            ram_we_reg   <= B_WE;
            ram_di_reg   <= B_DI;
            ram_cs_reg   <= 1'b1;
         end else begin
            // Address and data stay put in IDLE; only the strobes drop.
            ram_we_reg <= 1'b0;
            ram_cs_reg <= 1'b0;
         end
         if (state_reg == SVC_A) begin
            a_do_reg  <= RAM_DO;
            a_ack_reg <= 1'b1;
         end
         if (state_reg == SVC_B) begin
            b_do_reg  <= RAM_DO;
            b_ack_reg <= 1'b1;
         end
      end
   end

`ifdef RAM_ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_b_reg <= 1'b1;
      else if (grant_a)
         last_b_reg <= 1'b0;
      else if (grant_b)
         last_b_reg <= 1'b1;
   end
`endif

   assign A_DO     = a_do_reg;
   assign B_DO     = b_do_reg;
   assign A_ACK    = a_ack_reg;
   assign B_ACK    = b_ack_reg;
   assign RAM_ADDR = ram_addr_reg;
   assign RAM_WE   = ram_we_reg;
   assign RAM_CS   = ram_cs_reg;
   assign RAM_DI   = ram_di_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural asynchronous-read RAM model.
// Expectations follow RAM_ARB_ROUND_ROBIN_EN when it is defined for both files.
module tb_ram_arbiter;

   logic        clk;
   logic        rst;
   logic        A_REQ, A_WE, B_REQ, B_WE;
   logic [13:0] A_ADDR, B_ADDR;
   logic [7:0]  A_DI, B_DI;
   logic [7:0]  A_DO, B_DO;
   logic        A_ACK, B_ACK;
   logic [13:0] RAM_ADDR;
   logic        RAM_WE, RAM_CS;
   logic [7:0]  RAM_DI;
   wire  [7:0]  RAM_DO;

   logic [7:0]  mem [0:16383];
   logic        preload;
   int          vectors = 0;
   int          miscompares = 0;
   logic        first_a;
   logic        exp_a, exp_b;

   ram_arbiter dut (
      .clk(clk), .rst(rst),
      .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_DI(A_DI), .A_DO(A_DO), .A_ACK(A_ACK),
      .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_DI(B_DI), .B_DO(B_DO), .B_ACK(B_ACK),
      .RAM_ADDR(RAM_ADDR), .RAM_WE(RAM_WE), .RAM_CS(RAM_CS), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM: write-through when WE is high, floating when deselected.
   assign RAM_DO = RAM_CS ? (RAM_WE ? RAM_DI : mem[RAM_ADDR]) : 8'hzz;

   always @(posedge clk) begin
      if (preload) begin
         mem[14'h0123] <= 8'h5A;
         mem[14'h0010] <= 8'h00;
         mem[14'h3FFF] <= 8'h00;
      end else if (RAM_CS && RAM_WE) begin
         mem[RAM_ADDR] <= RAM_DI;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; preload = 1'b1;
      A_REQ = 1'b0; A_WE = 1'b0; A_ADDR = 14'h0; A_DI = 8'h0;
      B_REQ = 1'b0; B_WE = 1'b0; B_ADDR = 14'h0; B_DI = 8'h0;
      step(); step();
      preload = 1'b0;
      check("rst_a_ack", A_ACK, 0);
      check("rst_b_ack", B_ACK, 0);
      check("rst_a_do", A_DO, 8'h00);
      check("rst_b_do", B_DO, 8'h00);
      check("rst_cs", RAM_CS, 0);
      check("rst_we", RAM_WE, 0);
      check("rst_addr", RAM_ADDR, 14'h0000);
      check("rst_di", RAM_DI, 8'h00);
      rst = 1'b0;
      step();

      // single read of a preloaded location
      A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 14'h0123;
      step();
      check("rd_svc_cs", RAM_CS, 1);
      check("rd_svc_we", RAM_WE, 0);
      check("rd_svc_addr", RAM_ADDR, 14'h0123);
      check("rd_svc_ack", A_ACK, 0);
      step();
      check("rd_ack", A_ACK, 1);
      check("rd_do", A_DO, 8'h5A);
      check("rd_ack_cs", RAM_CS, 0);
      check("rd_b_ack", B_ACK, 0);
      A_REQ = 1'b0;
      step();
      check("rd_ack_end", A_ACK, 0);
      check("rd_idle_cs", RAM_CS, 0);
      check("rd_do_hold", A_DO, 8'h5A);
      check("rd_idle_addr", RAM_ADDR, 14'h0123);

      // B writes the top address, A reads it back
      B_REQ = 1'b1; B_WE = 1'b1; B_ADDR = 14'h3FFF; B_DI = 8'hC3;
      step();
      check("wr_svc_cs", RAM_CS, 1);
      check("wr_svc_we", RAM_WE, 1);
      check("wr_svc_addr", RAM_ADDR, 14'h3FFF);
      check("wr_svc_di", RAM_DI, 8'hC3);
      step();
      check("wr_ack", B_ACK, 1);
      check("wr_do", B_DO, 8'hC3);
      check("wr_we_off", RAM_WE, 0);
      check("wr_a_do_kept", A_DO, 8'h5A);
      check("wr_a_ack", A_ACK, 0);
      check("wr_mem", mem[14'h3FFF], 8'hC3);
      B_REQ = 1'b0; B_WE = 1'b0;
      step();
      A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 14'h3FFF;
      step();
      check("rb_svc_cs", RAM_CS, 1);
      step();
      check("rb_ack", A_ACK, 1);
      check("rb_do", A_DO, 8'hC3);
      check("rb_b_do_kept", B_DO, 8'hC3);
      A_REQ = 1'b0;
      step();

      // simultaneous fresh requests after A was the last winner
`ifdef RAM_ARB_ROUND_ROBIN_EN
      first_a = 1'b0;
`else
      first_a = 1'b1;
`endif
      A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 14'h0123;
      B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 14'h3FFF;
      for (int k = 1; k <= 12; k++) begin
         step();
         exp_a = first_a ? ((k % 4) == 2) : ((k % 4) == 0);
         exp_b = first_a ? ((k % 4) == 0) : ((k % 4) == 2);
         check($sformatf("ct_a_ack_k%0d", k), A_ACK, exp_a);
         check($sformatf("ct_b_ack_k%0d", k), B_ACK, exp_b);
         if (k == 1)
            check("ct_first_addr", RAM_ADDR, first_a ? 14'h0123 : 14'h3FFF);
      end
      A_REQ = 1'b0; B_REQ = 1'b0;
      check("ct_a_do", A_DO, 8'h5A);
      check("ct_b_do", B_DO, 8'hC3);
      step(); step();

      // A request that appears during B's access and vanishes is dropped
      B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 14'h0010;
      step();
      A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 14'h0123;
      step();
      check("drop_b_ack", B_ACK, 1);
      check("drop_b_do", B_DO, 8'h00);
      A_REQ = 1'b0; B_REQ = 1'b0;
      step();
      check("drop_cs", RAM_CS, 0);
      check("drop_a_ack0", A_ACK, 0);
      step();
      check("drop_a_ack1", A_ACK, 0);
      check("drop_cs1", RAM_CS, 0);

      // held request: next access only after the ACK cycle
      A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 14'h0010;
      step();
      check("hold_svc1_cs", RAM_CS, 1);
      step();
      check("hold_ack1", A_ACK, 1);
      check("hold_ack1_cs", RAM_CS, 0);
      step();
      check("hold_gap_cs", RAM_CS, 0);
      check("hold_gap_ack", A_ACK, 0);
      step();
      check("hold_svc2_cs", RAM_CS, 1);
      check("hold_svc2_addr", RAM_ADDR, 14'h0010);
      step();
      check("hold_ack2", A_ACK, 1);
      check("hold_do", A_DO, 8'h00);
      A_REQ = 1'b0;
      step();
      check("hold_end_ack", A_ACK, 0);
      check("hold_end_cs", RAM_CS, 0);

      // reset arrives during B's write
      B_REQ = 1'b1; B_WE = 1'b1; B_ADDR = 14'h0010; B_DI = 8'hFF;
      step();
      check("mw_svc_cs", RAM_CS, 1);
      check("mw_svc_we", RAM_WE, 1);
      #2 rst = 1'b1;
      #1;
      check("mw_rst_cs", RAM_CS, 0);
      check("mw_rst_we", RAM_WE, 0);
      step();
      check("mw_b_ack", B_ACK, 0);
      check("mw_mem", mem[14'h0010], 8'h00);
      check("mw_a_do", A_DO, 8'h00);
      check("mw_b_do", B_DO, 8'h00);
      check("mw_addr", RAM_ADDR, 14'h0000);
      check("mw_di", RAM_DI, 8'h00);
      check("mw_a_ack", A_ACK, 0);
      B_REQ = 1'b0; B_WE = 1'b0;
      rst = 1'b0;
      step();
      check("mw_post_b_ack", B_ACK, 0);
      check("mw_post_cs", RAM_CS, 0);
      check("mw_post_mem", mem[14'h0010], 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
